// File: rtl/pu_out_checker.sv
// Scoreboard for the PU write stream: compares accepted beats against a FIFO of expected vectors.
// Define PU_CHECK_TOLERANCE_EN for a signed |obs-exp| <= tolerance compare; otherwise lanes must match exactly.
module pu_out_checker #(
  parameter int NUM_PE    = 4,
  parameter int OP_WIDTH  = 16,
  parameter int EXP_DEPTH = 16,
  parameter int CNT_W     = 16,
  parameter int TOL_W     = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [CNT_W-1:0]             expected_count,
  input  logic                         exp_push,
  input  logic [NUM_PE*OP_WIDTH-1:0]   exp_data,
  output logic                         exp_ready,
  input  logic                         obs_valid,
  input  logic [NUM_PE*OP_WIDTH-1:0]   obs_data,
  output logic                         obs_ready,
  input  logic [NUM_PE-1:0]            lane_mask,
  input  logic [TOL_W-1:0]             tolerance,
  output logic                         busy,
  output logic                         done,
  output logic                         pass,
  output logic                         fail,
  output logic [CNT_W-1:0]             err_count,
  output logic [CNT_W-1:0]             first_err_index,
  output logic [NUM_PE-1:0]            lane_err
);

  localparam int AW = $clog2(EXP_DEPTH);
  localparam int VW = NUM_PE * OP_WIDTH;

  typedef enum logic [1:0] {IDLE, CHECK, DONE} state_t;
  state_t state_q, state_d;

  logic [VW-1:0]     fifo_mem [EXP_DEPTH];
  logic [AW:0]       wr_ptr, rd_ptr, fifo_cnt;
  logic              fifo_full, fifo_empty, push, pop, accept;
  logic [VW-1:0]     exp_head;
  logic [CNT_W-1:0]  exp_cnt_r, beat_idx, idx_p1;
  logic [NUM_PE-1:0] mask_r, mis_p0, mis_p1;
  logic              vld_p1, last_p1, overrun;

`ifdef PU_CHECK_TOLERANCE_EN
  logic [TOL_W-1:0]  tol_r;

  function automatic logic lane_mismatch(input logic signed [OP_WIDTH-1:0] o,
                                         input logic signed [OP_WIDTH-1:0] e,
                                         input logic [TOL_W-1:0] tol);
    logic signed [OP_WIDTH:0] d;
    logic [OP_WIDTH:0]        mag;
    d   = (OP_WIDTH+1)'(o) - (OP_WIDTH+1)'(e);
    mag = d[OP_WIDTH] ? (OP_WIDTH+1)'(-d) : (OP_WIDTH+1)'(d);
    return mag > (OP_WIDTH+1)'(tol);
  endfunction
`else
  logic unused_tol;
  assign unused_tol = ^tolerance;

  function automatic logic lane_mismatch(input logic signed [OP_WIDTH-1:0] o,
                                         input logic signed [OP_WIDTH-1:0] e);
    return o != e;
  endfunction
`endif

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign fifo_cnt   = wr_ptr - rd_ptr;
  assign fifo_full  = (fifo_cnt == (AW+1)'(EXP_DEPTH));
  assign fifo_empty = (fifo_cnt == '0);
  assign exp_ready  = ~fifo_full;
  assign push       = exp_push & ~fifo_full;
  assign exp_head   = fifo_mem[rd_ptr[AW-1:0]];

  // start takes priority, so no beat is accepted in the cycle that re-arms a run
  assign obs_ready = ~start & (((state_q == CHECK) & ~fifo_empty & (beat_idx < exp_cnt_r)) |
                               (state_q == DONE));
  assign accept    = obs_valid & obs_ready;
  assign pop       = accept & (state_q == CHECK);

  assign busy = (state_q == CHECK);
  assign done = (state_q == DONE);
  assign pass = done & (err_count == '0) & ~overrun;
  assign fail = done & ~pass;

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr[AW-1:0]] <= exp_data;
    if (start) begin
      exp_cnt_r <= expected_count;
      mask_r    <= lane_mask;
`ifdef PU_CHECK_TOLERANCE_EN
      tol_r     <= tolerance;
`endif
    end
  end

  // p0: per-lane compare of the beat being handshaken against the FIFO head
  always_comb begin
    mis_p0 = '0;
    for (int i = 0; i < NUM_PE; i++) begin
`ifdef PU_CHECK_TOLERANCE_EN
      mis_p0[i] = mask_r[i] & lane_mismatch($signed(obs_data[i*OP_WIDTH +: OP_WIDTH]),
                                             $signed(exp_head[i*OP_WIDTH +: OP_WIDTH]), tol_r);
`else
      mis_p0[i] = mask_r[i] & lane_mismatch($signed(obs_data[i*OP_WIDTH +: OP_WIDTH]),
                                             $signed(exp_head[i*OP_WIDTH +: OP_WIDTH]));
`endif
    end
  end

  // p1: registered mismatch flags and beat index
  always_ff @(posedge clk) begin
    if (pop) begin
      mis_p1 <= mis_p0;
      idx_p1 <= beat_idx;
    end
  end

  assign last_p1 = (idx_p1 == exp_cnt_r - 1'b1);

  always_comb begin
    state_d = state_q;
    if (start)
      state_d = (expected_count == '0) ? DONE : CHECK;
    else if ((state_q == CHECK) && vld_p1 && last_p1)
      state_d = DONE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= IDLE;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      beat_idx        <= '0;
      vld_p1          <= 1'b0;
      overrun         <= 1'b0;
      err_count       <= '0;
      lane_err        <= '0;
      first_err_index <= '1;
    end else begin
      state_q <= state_d;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (start) begin
        beat_idx        <= '0;
        vld_p1          <= 1'b0;
        overrun         <= 1'b0;
        err_count       <= '0;
        lane_err        <= '0;
        first_err_index <= '1;
      end else begin
        vld_p1 <= pop;
        if (pop) beat_idx <= beat_idx + 1'b1;
        if (accept && (state_q == DONE)) overrun <= 1'b1;
        // p2: fold the registered compare into the error summary
        if (vld_p1 && (|mis_p1)) begin
          err_count <= sat_inc(err_count);
          lane_err  <= lane_err | mis_p1;
          if (err_count == '0) first_err_index <= idx_p1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pu_out_checker.sv
// Self-checking bench for pu_out_checker: a bench-side FIFO model and per-beat scoreboard.
module tb_pu_out_checker;

  localparam int NUM_PE    = 4;
  localparam int OP_WIDTH  = 16;
  localparam int EXP_DEPTH = 16;
  localparam int CNT_W     = 16;
  localparam int TOL_W     = 4;
  localparam int VW        = NUM_PE * OP_WIDTH;

  logic              clk, reset, start, exp_push, exp_ready, obs_valid, obs_ready;
  logic [CNT_W-1:0]  expected_count, err_count, first_err_index;
  logic [VW-1:0]     exp_data, obs_data;
  logic [NUM_PE-1:0] lane_mask, lane_err;
  logic [TOL_W-1:0]  tolerance;
  logic              busy, done, pass, fail;

  pu_out_checker #(.NUM_PE(NUM_PE), .OP_WIDTH(OP_WIDTH), .EXP_DEPTH(EXP_DEPTH),
                   .CNT_W(CNT_W), .TOL_W(TOL_W)) dut (
    .clk(clk), .reset(reset), .start(start), .expected_count(expected_count),
    .exp_push(exp_push), .exp_data(exp_data), .exp_ready(exp_ready),
    .obs_valid(obs_valid), .obs_data(obs_data), .obs_ready(obs_ready),
    .lane_mask(lane_mask), .tolerance(tolerance), .busy(busy), .done(done),
    .pass(pass), .fail(fail), .err_count(err_count),
    .first_err_index(first_err_index), .lane_err(lane_err)
  );

  typedef struct {
    int                due;
    logic [CNT_W-1:0]  err;
    logic [NUM_PE-1:0] lane;
    logic [CNT_W-1:0]  first;
  } sb_t;

  sb_t               sb_q[$];
  sb_t               mon_e;
  logic [VW-1:0]     mfifo[$];
  int                n_checks = 0;
  int                n_pass = 0;
  int                cyc = 0;
  logic [CNT_W-1:0]  m_err, m_first;
  logic [NUM_PE-1:0] m_lane, m_mask;
  logic [TOL_W-1:0]  m_tol;
  int                m_idx, m_target;
  bit                m_overrun;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got running want finished");
    $fatal(1, "watchdog");
  end

  // Scoreboard: each accepted beat's expected error summary is due two cycles after its handshake.
  always @(negedge clk) begin
    if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
      mon_e = sb_q.pop_front();
      n_checks++;
      if (err_count !== mon_e.err || lane_err !== mon_e.lane || first_err_index !== mon_e.first)
        $display("FAIL sb_beat cyc=%0d: got err=%0d lane=%b first=%0d want err=%0d lane=%b first=%0d",
                 cyc, err_count, lane_err, first_err_index, mon_e.err, mon_e.lane, mon_e.first);
      else n_pass++;
    end
  end

  function automatic logic [VW-1:0] rand_vec();
    logic [VW-1:0] v;
    for (int i = 0; i < NUM_PE; i++)
      v[i*OP_WIDTH +: OP_WIDTH] = OP_WIDTH'($urandom_range(0, 16000)) - OP_WIDTH'(8000);
    return v;
  endfunction

  function automatic logic [VW-1:0] lane_delta(input int lane, input int d);
    logic [VW-1:0] v;
    v = '0;
    v[lane*OP_WIDTH +: OP_WIDTH] = OP_WIDTH'(d);
    return v;
  endfunction

  function automatic logic [NUM_PE-1:0] model_mis(input logic [VW-1:0] o, input logic [VW-1:0] e);
    logic [NUM_PE-1:0] r;
    int ov, ev, diff;
    r = '0;
    for (int i = 0; i < NUM_PE; i++) begin
      ov = int'($signed(o[i*OP_WIDTH +: OP_WIDTH]));
      ev = int'($signed(e[i*OP_WIDTH +: OP_WIDTH]));
      diff = ov - ev;
      if (diff < 0) diff = -diff;
`ifdef PU_CHECK_TOLERANCE_EN
      r[i] = m_mask[i] && (diff > int'(m_tol));
`else
      r[i] = m_mask[i] && (diff != 0);
`endif
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push_vec(input logic [VW-1:0] v);
    exp_push = 1'b1;
    exp_data = v;
    if (mfifo.size() < EXP_DEPTH) mfifo.push_back(v);
    tick();
    exp_push = 1'b0;
  endtask

  task automatic do_start(input int cnt, input logic [NUM_PE-1:0] mask, input logic [TOL_W-1:0] tol);
    sb_q.delete();
    m_err = '0; m_lane = '0; m_first = '1; m_idx = 0; m_overrun = 0;
    m_target = cnt; m_mask = mask; m_tol = tol;
    start = 1'b1; expected_count = CNT_W'(cnt); lane_mask = mask; tolerance = tol;
    tick();
    start = 1'b0;
  endtask

  // Drives one beat built from the model FIFO head plus per-lane deltas; waits (bounded) for acceptance.
  task automatic send_beat(input logic [VW-1:0] delta);
    logic [VW-1:0]     head, o;
    logic [NUM_PE-1:0] mis;
    bit                chk;
    int                k;
    chk  = (m_idx < m_target);
    head = (chk && mfifo.size() > 0) ? mfifo[0] : '0;
    for (int i = 0; i < NUM_PE; i++)
      o[i*OP_WIDTH +: OP_WIDTH] = head[i*OP_WIDTH +: OP_WIDTH] + delta[i*OP_WIDTH +: OP_WIDTH];
    obs_valid = 1'b1;
    obs_data  = o;
    k = 0;
    @(negedge clk);
    while (!obs_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!obs_ready) begin
      n_checks++;
      $display("FAIL beat_accept: got obs_ready=0 for 50 cycles, want 1");
    end else if (chk) begin
      void'(mfifo.pop_front());
      mis = model_mis(o, head);
      if (|mis) begin
        if (m_err == '0) m_first = CNT_W'(m_idx);
        if (m_err != '1) m_err = m_err + 1'b1;
        m_lane = m_lane | mis;
      end
      m_idx++;
      sb_q.push_back('{cyc + 2, m_err, m_lane, m_first});
    end else begin
      m_overrun = 1;
    end
    tick();
    obs_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; expected_count = '0; exp_push = 1'b0; exp_data = '0;
    obs_valid = 1'b0; obs_data = '0; lane_mask = '0; tolerance = '0;
    #12;
    n_checks++;
    if (exp_ready !== 1'b1 || obs_ready !== 1'b0)
      $display("FAIL reset_ready: got exp_ready=%b obs_ready=%b want 1 0", exp_ready, obs_ready);
    else n_pass++;
    n_checks++;
    if ({busy, done, pass, fail} !== 4'b0000)
      $display("FAIL reset_status: got busy/done/pass/fail=%b want 0000", {busy, done, pass, fail});
    else n_pass++;
    n_checks++;
    if (err_count !== '0 || first_err_index !== '1 || lane_err !== '0)
      $display("FAIL reset_counters: got err=%h first=%h lane=%b want 0 ffff 0",
               err_count, first_err_index, lane_err);
    else n_pass++;
    tick();
    reset = 1'b1;
    tick(); tick();
    n_checks++;
    if (obs_ready !== 1'b0 || busy !== 1'b0)
      $display("FAIL idle_after_reset: got obs_ready=%b busy=%b want 0 0", obs_ready, busy);
    else n_pass++;
  endtask

  task automatic test_exact_match();
    for (int i = 0; i < 8; i++) push_vec(rand_vec());
    do_start(8, 4'hF, '0);
    for (int i = 0; i < 8; i++) send_beat('0);
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b1)
      $display("FAIL exact_done_early: got done=%b busy=%b want 0 1", done, busy);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b0 || pass !== 1'b1 || fail !== 1'b0)
      $display("FAIL exact_done: got done=%b busy=%b pass=%b fail=%b want 1 0 1 0", done, busy, pass, fail);
    else n_pass++;
    n_checks++;
    if (err_count !== 16'd0 || first_err_index !== 16'hFFFF)
      $display("FAIL exact_counters: got err=%0d first=%h want 0 ffff", err_count, first_err_index);
    else n_pass++;
  endtask

  task automatic test_lane_error();
    logic [NUM_PE-1:0] mask, want_lane;
    logic [CNT_W-1:0]  want_err, want_first;
    logic              want_pass;
    for (int r = 0; r < 2; r++) begin
      mask       = (r == 0) ? 4'hF : 4'hB;
      want_err   = (r == 0) ? 16'd1 : 16'd0;
      want_first = (r == 0) ? 16'd3 : 16'hFFFF;
      want_lane  = (r == 0) ? 4'b0100 : 4'b0000;
      want_pass  = (r == 0) ? 1'b0 : 1'b1;
      for (int i = 0; i < 8; i++) push_vec(rand_vec());
      do_start(8, mask, '0);
      for (int i = 0; i < 8; i++) send_beat((i == 3) ? lane_delta(2, 5) : '0);
      @(negedge clk); @(negedge clk);
      n_checks++;
      if (err_count !== want_err || first_err_index !== want_first || lane_err !== want_lane)
        $display("FAIL lane_err_counters r=%0d: got err=%0d first=%0d lane=%b want %0d %0d %b",
                 r, err_count, first_err_index, lane_err, want_err, want_first, want_lane);
      else n_pass++;
      n_checks++;
      if (done !== 1'b1 || pass !== want_pass || fail !== ~want_pass)
        $display("FAIL lane_err_result r=%0d: got done=%b pass=%b fail=%b want 1 %b %b",
                 r, done, pass, fail, want_pass, ~want_pass);
      else n_pass++;
    end
  endtask

  task automatic test_tolerance();
    logic [VW-1:0] v;
    logic          want_pass_a;
`ifdef PU_CHECK_TOLERANCE_EN
    want_pass_a = 1'b1;
`else
    want_pass_a = 1'b0;
`endif
    for (int i = 0; i < 4; i++) push_vec(rand_vec());
    do_start(4, 4'hF, 4'd2);
    send_beat(lane_delta(0, -2));
    send_beat(lane_delta(1, 2));
    send_beat(lane_delta(3, -2) | lane_delta(2, 2));
    send_beat('0);
    @(negedge clk); @(negedge clk);
    n_checks++;
    if (done !== 1'b1 || pass !== want_pass_a)
      $display("FAIL tol_within: got done=%b pass=%b want 1 %b", done, pass, want_pass_a);
    else n_pass++;

    for (int i = 0; i < 4; i++) push_vec(rand_vec());
    do_start(4, 4'hF, 4'd2);
    for (int i = 0; i < 4; i++) send_beat((i == 1) ? lane_delta(0, -3) : '0);
    @(negedge clk); @(negedge clk);
    n_checks++;
    if (fail !== 1'b1 || first_err_index !== 16'd1 || lane_err !== 4'b0001)
      $display("FAIL tol_exceed: got fail=%b first=%0d lane=%b want 1 1 0001", fail, first_err_index, lane_err);
    else n_pass++;

    v = rand_vec();
    v[OP_WIDTH-1:0] = 16'h7FFF;
    push_vec(v);
    do_start(1, 4'hF, 4'd2);
    send_beat(lane_delta(0, 1));
    @(negedge clk); @(negedge clk);
    n_checks++;
    if (fail !== 1'b1 || err_count !== 16'd1 || lane_err !== 4'b0001)
      $display("FAIL tol_no_wrap: got fail=%b err=%0d lane=%b want 1 1 0001", fail, err_count, lane_err);
    else n_pass++;
  endtask

  task automatic test_flow_control();
    logic [VW-1:0] v;
    do_start(4, 4'hF, '0);
    obs_valid = 1'b1;
    obs_data  = '0;
    @(negedge clk); @(negedge clk); @(negedge clk);
    n_checks++;
    if (obs_ready !== 1'b0 || busy !== 1'b1)
      $display("FAIL ready_empty: got obs_ready=%b busy=%b want 0 1", obs_ready, busy);
    else n_pass++;
    tick();
    v = rand_vec();
    push_vec(v);
    obs_data = v;
    @(negedge clk);
    n_checks++;
    if (obs_ready !== 1'b1)
      $display("FAIL ready_after_push: got obs_ready=%b want 1", obs_ready);
    else n_pass++;
    void'(mfifo.pop_front());
    m_idx++;
    sb_q.push_back('{cyc + 2, m_err, m_lane, m_first});
    tick();
    obs_valid = 1'b0;

    for (int i = 0; i < EXP_DEPTH; i++) push_vec(rand_vec());
    n_checks++;
    if (exp_ready !== 1'b0)
      $display("FAIL fifo_full: got exp_ready=%b want 0", exp_ready);
    else n_pass++;
    push_vec(rand_vec());
    do_start(EXP_DEPTH, 4'hF, '0);
    for (int i = 0; i < EXP_DEPTH; i++) send_beat('0);
    @(negedge clk); @(negedge clk);
    n_checks++;
    if (done !== 1'b1 || pass !== 1'b1)
      $display("FAIL full_drain: got done=%b pass=%b want 1 1", done, pass);
    else n_pass++;
    do_start(1, 4'hF, '0);
    @(negedge clk);
    n_checks++;
    if (obs_ready !== (mfifo.size() > 0) || exp_ready !== 1'b1)
      $display("FAIL entry_count: got obs_ready=%b exp_ready=%b want %b 1",
               obs_ready, exp_ready, mfifo.size() > 0);
    else n_pass++;
    tick();
  endtask

  task automatic test_overrun_restart();
    for (int i = 0; i < 2; i++) push_vec(rand_vec());
    do_start(2, 4'hF, '0);
    for (int i = 0; i < 3; i++) send_beat('0);
    @(negedge clk);
    n_checks++;
    if (done !== 1'b1 || fail !== 1'b1 || pass !== 1'b0 || m_overrun != 1)
      $display("FAIL overrun: got done=%b fail=%b pass=%b want 1 1 0", done, fail, pass);
    else n_pass++;

    for (int i = 0; i < 4; i++) push_vec(rand_vec());
    do_start(4, 4'hF, '0);
    send_beat(lane_delta(1, 1));
    send_beat('0);
    tick(); tick();
    n_checks++;
    if (err_count !== 16'd1 || lane_err !== 4'b0010)
      $display("FAIL pre_restart: got err=%0d lane=%b want 1 0010", err_count, lane_err);
    else n_pass++;
    do_start(2, 4'hF, '0);
    n_checks++;
    if (err_count !== '0 || lane_err !== '0 || first_err_index !== '1 || busy !== 1'b1 || done !== 1'b0)
      $display("FAIL restart_clear: got err=%0d lane=%b first=%h busy=%b done=%b want 0 0 ffff 1 0",
               err_count, lane_err, first_err_index, busy, done);
    else n_pass++;
    for (int i = 0; i < 2; i++) send_beat('0);
    @(negedge clk); @(negedge clk);
    n_checks++;
    if (done !== 1'b1 || pass !== 1'b1)
      $display("FAIL restart_run: got done=%b pass=%b want 1 1", done, pass);
    else n_pass++;

    for (int i = 0; i < 2; i++) push_vec(rand_vec());
    do_start(2, 4'hF, '0);
    send_beat(lane_delta(3, 1));
    @(posedge clk);
    @(posedge clk);
    #2;
    n_checks++;
    if (err_count !== 16'd1 || busy !== 1'b1)
      $display("FAIL pre_reset: got err=%0d busy=%b want 1 1", err_count, busy);
    else n_pass++;
    #1 reset = 1'b0;
    #1;
    n_checks++;
    if (err_count !== '0 || first_err_index !== '1 || lane_err !== '0)
      $display("FAIL async_reset_counters: got err=%0d first=%h lane=%b want 0 ffff 0",
               err_count, first_err_index, lane_err);
    else n_pass++;
    n_checks++;
    if ({busy, done, pass, fail} !== 4'b0000 || exp_ready !== 1'b1 || obs_ready !== 1'b0)
      $display("FAIL async_reset_status: got b/d/p/f=%b exp_ready=%b obs_ready=%b want 0000 1 0",
               {busy, done, pass, fail}, exp_ready, obs_ready);
    else n_pass++;
    mfifo.delete();
    sb_q.delete();
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_zero_count();
    push_vec(rand_vec());
    do_start(0, 4'hF, '0);
    n_checks++;
    if (done !== 1'b1 || pass !== 1'b1 || busy !== 1'b0 || err_count !== '0)
      $display("FAIL zero_count: got done=%b pass=%b busy=%b err=%0d want 1 1 0 0",
               done, pass, busy, err_count);
    else n_pass++;
    tick();
  endtask

  initial begin
    test_reset();
    test_exact_match();
    test_lane_error();
    test_tolerance();
    test_flow_control();
    test_overrun_restart();
    test_zero_count();
    tick(); tick(); tick();
    n_checks++;
    if (sb_q.size() != 0)
      $display("FAIL sb_leftover: got %0d pending beats want 0", sb_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pu_out_checker.md
# pu_out_checker

Synthesizable, self-checking scoreboard for the PU write stream. It holds a parametrised FIFO of expected NUM_PE-lane output vectors. Each accepted PU output beat is compared against the head of that FIFO, lane by lane, under a lane mask and an optional signed tolerance. It counts errors, records the first failing beat and the failing lanes, and reports pass/fail when the programmed beat count has retired. It sits on the PU `write_data`/`write_req` path in place of a behavioural driver, so the same checks run in simulation and on FPGA.

## Interface
- NUM_PE, 4, lanes per beat
- OP_WIDTH, 16, bits per lane (signed two's complement)
- EXP_DEPTH, 16, expected-FIFO depth; power of 2, ≥2
- CNT_W, 16, beat/error counter width
- TOL_W, 4, tolerance width (unsigned)

Ports:
- clk  in  1  clock; all logic rising-edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  pulse; arms a check run
- expected_count  in  CNT_W  beats in run, sampled on start
- exp_push  in  1  expected-vector write
- exp_data  in  NUM_PE*OP_WIDTH  expected vector; lane i at [i*OP_WIDTH +: OP_WIDTH]
- exp_ready  out  1  FIFO not full
- obs_valid  in  1  PU write_req
- obs_data  in  NUM_PE*OP_WIDTH  PU write_data
- obs_ready  out  1  beat accepted when obs_valid && obs_ready
- lane_mask  in  NUM_PE  1 = lane checked; sampled on start
- tolerance  in  TOL_W  max allowed |obs−exp|; sampled on start
- busy  out  1  run in progress
- done  out  1  run complete
- pass  out  1  done && no errors && no overrun
- fail  out  1  done && (errors || overrun)
- err_count  out  CNT_W  mismatching beats, saturating
- first_err_index  out  CNT_W  index of first failing beat; all-ones = none
- lane_err  out  NUM_PE  sticky per-lane mismatch flags

## Operation
- FSM states: IDLE, CHECK, DONE. Reset → IDLE.
- IDLE: on start, go to CHECK. If expected_count==0, go to DONE instead.
- Any state: start clears err_count, lane_err, first_err_index, the overrun flag, the beat index and the compare stage, then re-arms the run. start does not flush the FIFO.
- FIFO push: occurs when exp_push && exp_ready. A push while full is dropped, including when a pop happens in the same cycle.
- FIFO contents are retained across runs; only reset empties it. Pointers wrap modulo EXP_DEPTH.
- obs_ready is 1 in CHECK when the FIFO is non-empty and the number of accepted beats is < expected_count.
- obs_ready is 1 in DONE, where beats are accepted and discarded. It is 0 in IDLE.
- Beat accepted in CHECK: pop the FIFO head and increment the beat index.
- Lane compare: lane i mismatches if lane_mask[i] and |obs−exp| > tolerance. The difference is computed sign-extended to OP_WIDTH+1 bits, so it never overflows.
- A beat with any lane mismatch: err_count increments (saturating at all-ones), and lane_err is ORed with the per-lane mismatch flags.
- first_err_index latches the beat index of the first failing beat only.
- Beat accepted in DONE: sets overrun, so fail=1 and pass=0.
- Run end: when the last beat's compare has retired, go to DONE. The FSM stays in DONE until start or reset.

## Timing
- Reset values: exp_ready=1, obs_ready=0, busy=0, done=0, pass=0, fail=0, err_count=0, first_err_index=all-ones, lane_err=0, FIFO empty.
- Compare pipeline:
  - Handshake in cycle N.
  - Per-lane mismatch is registered at the end of N.
  - err_count, lane_err and first_err_index update at the end of N+1.
- Last beat handshake in cycle N: done, pass and fail are valid from cycle N+2. busy=0 in that same cycle.
- busy is high from the cycle after start until DONE.
- A pushed vector is poppable from the cycle after the push. A push and a pop in the same cycle are legal when the FIFO is neither full nor empty.
- Reset mid-run: immediate return to reset values; the in-flight compare is discarded.

## Configuration
- PU_CHECK_TOLERANCE_EN defined: tolerance compare as above.
- PU_CHECK_TOLERANCE_EN undefined: exact compare (obs==exp per masked lane). The tolerance input is ignored and no subtractors are built.

## Test plan
- Exact match: NUM_PE=4, preload 8 vectors, expected_count=8, mask=4'hF, identical observed stream → done at last handshake+2, pass=1, err_count=0, first_err_index=16'hFFFF.
- Single lane error: beat 3, lane 2 off by +5, tolerance=0 → err_count=1, first_err_index=3, lane_err=4'b0100, fail=1. Repeat with lane 2 masked (mask=4'hB) → pass=1.
- Tolerance (macro defined): tolerance=2; lane diffs of −2 and +2 → pass. Lane diff of −3 → fail. exp=16'h7FFF vs obs=16'h8000 → mismatch (no wrap).
- Flow control: preload 0 vectors, hold obs_valid=1 → obs_ready=0. Push one vector → obs_ready=1 the next cycle. Fill FIFO to EXP_DEPTH → exp_ready=0; an extra push is dropped (verified by entry count).
- Overrun/restart: expected_count=2, send 3 beats → the third is accepted in DONE and fail=1. Assert start mid-run → counters cleared and the run restarts. Pull reset low asynchronously mid-run → all outputs return to reset values without a clock edge.
- Zero count: start with expected_count=0 → DONE the next cycle, pass=1.
